// File: rtl/auction_pkg.sv
// Shared types for the auction pipeline: bid width, slot count, bid type and
// the collector FSM states. The argmax stage imports this package as well.
package auction_pkg;

  localparam int bW      = 17;
  localparam int NB      = 10;
  localparam int TIMER_W = 8;
  localparam int RID_W   = 8;

  typedef logic [bW-1:0] bid_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // Window closes on its last timer cycle or once every slot holds a bid.
  function automatic logic window_closes(input logic [TIMER_W-1:0] timer,
                                         input logic [TIMER_W-1:0] last,
                                         input logic               all_in);
    return (timer == last) || all_in;
  endfunction

endpackage

// File: rtl/bid_slot.sv
// One bidder slot: captures the first offered bid of a round and raises its
// mask bit; ready is decoded from the enable and the registered mask only.
module bid_slot #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         accept_o,
  output logic [W-1:0] bid_o,
  output logic         mask_o
);

  logic [W-1:0] bid_q, bid_d;
  logic         mask_q, mask_d;

  assign ready_o  = enable_i & ~mask_q;
  assign accept_o = valid_i & ready_o;

  always_comb begin
    bid_d  = bid_q;
    mask_d = mask_q;
    if (clear_i) begin
      bid_d  = '0;
      mask_d = 1'b0;
    end else if (accept_o) begin
      bid_d  = data_i;
      mask_d = 1'b1;
    end
  end

  // NOTE: the capture register is reset, not just the mask, because
  // downstream reads bids[i]=0 for slots that never submitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bid_q  <= '0;
      mask_q <= 1'b0;
    end else begin
      bid_q  <= bid_d;
      mask_q <= mask_d;
    end
  end

  assign bid_o  = bid_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/bid_collect10.sv
// Bid collector: opens a round on start, gathers one bid per slot for a
// bounded window, then presents the bid vector until downstream accepts it.
module bid_collect10 #(
  parameter int bW  = auction_pkg::bW,
  parameter int NB  = auction_pkg::NB,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NB-1:0] bid_valid,
  input  logic [bW-1:0] bid_data [NB-1:0],
  output logic [NB-1:0] bid_ready,
  output logic [bW-1:0] bids     [NB-1:0],
  output logic [NB-1:0] bid_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    round_id
);

  import auction_pkg::*;

  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TMO - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RID_W-1:0]   round_id_q, round_id_d;

  logic          collect;
  logic          clear;
  logic [NB-1:0] accept;
  logic [NB-1:0] mask_after;
  logic          window_end;

  assign collect = (state_q == COLLECT);
  assign clear   = (state_q == IDLE) && start;

  for (genvar i = 0; i < NB; i++) begin : g_slot
    bid_slot #(
      .W(bW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear),
      .enable_i (collect),
      .valid_i  (bid_valid[i]),
      .data_i   (bid_data[i]),
      .ready_o  (bid_ready[i]),
      .accept_o (accept[i]),
      .bid_o    (bids[i]),
      .mask_o   (bid_mask[i])
    );
  end

  // Mask as it will be after this cycle, so closing-cycle bids count.
  assign mask_after = bid_mask | accept;
  assign window_end = window_closes(timer_q, TMO_LAST, &mask_after);

  // NOTE: every variable gets its hold value first, so no branch can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    round_id_d = round_id_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          timer_d = '0;
        end
      end
      COLLECT: begin
        timer_d = timer_q + 1'b1;
        if (window_end) begin
          state_d = (|mask_after) ? PRESENT : IDLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d    = IDLE;
          round_id_d = round_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      round_id_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      round_id_q <= round_id_d;
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign round_id  = round_id_q;

endmodule

// File: tb/tb_bid_collect10.sv
// Self-checking bench for bid_collect10: expected rounds are queued as stimulus
// is driven and compared by a monitor whenever the collector presents a vector.
module tb_bid_collect10;

  import auction_pkg::*;

  typedef struct packed {
    logic [7:0]    rid;
    logic [9:0]    mask;
    bid_t [9:0]    bids;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  bid_valid;
  logic [16:0] bid_data [9:0];
  logic        out_ready;

  logic [9:0]  bid_ready;
  logic [16:0] bids [9:0];
  logic [9:0]  bid_mask;
  logic        out_valid;
  logic [7:0]  round_id;

  logic [9:0]  o4_bid_ready;
  logic [16:0] o4_bids [9:0];
  logic [9:0]  o4_bid_mask;
  logic        o4_out_valid;
  logic [7:0]  o4_round_id;

  exp_t sb[$];
  exp_t me;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_rid  = 0;

  always #5 clk = ~clk;

  bid_collect10 #(.bW(17), .NB(10), .TMO(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bid_valid(bid_valid), .bid_data(bid_data),
    .bid_ready(bid_ready), .bids(bids), .bid_mask(bid_mask), .out_valid(out_valid),
    .out_ready(out_ready), .round_id(round_id)
  );

  bid_collect10 #(.bW(17), .NB(10), .TMO(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bid_valid(bid_valid), .bid_data(bid_data),
    .bid_ready(o4_bid_ready), .bids(o4_bids), .bid_mask(o4_bid_mask), .out_valid(o4_out_valid),
    .out_ready(out_ready), .round_id(o4_round_id)
  );

  // Scoreboard monitor: every presented cycle must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_present: out_valid=1 mask=%h, no round expected", bid_mask);
      end else begin
        int bad;
        me  = sb[0];
        bad = -1;
        for (int i = 0; i < 10; i++) if (bids[i] !== me.bids[i]) bad = i;
        n_checks++;
        if (bid_mask !== me.mask) $display("FAIL sb_mask: got %h want %h", bid_mask, me.mask);
        else n_pass++;
        n_checks++;
        if (bad >= 0) $display("FAIL sb_bids: slot %0d got %h want %h", bad, bids[bad], me.bids[bad]);
        else n_pass++;
        n_checks++;
        if (round_id !== me.rid) $display("FAIL sb_round_id: got %0d want %0d", round_id, me.rid);
        else n_pass++;
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!out_valid && cyc <= budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_rid   = (exp_rid + 1) % 256;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; start = 1'b0; bid_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) bid_data[i] = '0;
    step(); step(); step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) if (bids[i] !== '0) bad++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (bid_ready !== '0) $display("FAIL reset_bid_ready: got %h want 000", bid_ready); else n_pass++;
    n_checks++; if (bid_mask !== '0) $display("FAIL reset_bid_mask: got %h want 000", bid_mask); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL reset_bids: %0d nonzero slots, want 0", bad); else n_pass++;
    n_checks++; if (round_id !== 8'd0) $display("FAIL reset_round_id: got %0d want 0", round_id); else n_pass++;
    exp_rid = 0;
  endtask

  task automatic test_full_round();
    exp_t e;
    e = '0; e.mask = 10'h3FF; e.rid = 8'(exp_rid);
    for (int i = 0; i < 10; i++) e.bids[i] = bid_t'(5 + i);
    sb.push_back(e);
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (bid_ready !== 10'h3FF) $display("FAIL full_ready: got %h want 3ff", bid_ready); else n_pass++;
    bid_valid = 10'h3FF;
    for (int i = 0; i < 10; i++) bid_data[i] = 17'(5 + i);
    step(); bid_valid = '0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL full_latency: out_valid=%b at cycle 2, want 1", out_valid); else n_pass++;
    n_checks++; if (bids[9] !== 17'd14) $display("FAIL full_bid9: got %0d want 14", bids[9]); else n_pass++;
    handshake();
    n_checks++; if (round_id !== 8'd1) $display("FAIL full_round_id: got %0d want 1", round_id); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL full_release: out_valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_timeout();
    exp_t e;
    int   cyc;
    e = '0; e.mask = 10'h008; e.bids[3] = 17'h1FFFF; e.rid = 8'(exp_rid);
    sb.push_back(e);
    start = 1'b1; step(); start = 1'b0;        // cycle 1, timer 0
    step();                                    // cycle 2
    bid_valid = 10'h008; bid_data[3] = 17'h1FFFF;
    step(); bid_valid = '0;                    // cycle 3
    n_checks++; if (bid_ready !== 10'h3F7) $display("FAIL timeout_ready: got %h want 3f7", bid_ready); else n_pass++;
    wait_valid(20, cyc);
    n_checks++; if (cyc !== 6) $display("FAIL timeout_latency: out_valid after %0d cycles, want 6 (cycle 9)", cyc); else n_pass++;
    handshake();
  endtask

  task automatic test_duplicate_and_closing();
    exp_t e;
    e = '0; e.mask = 10'h021; e.bids[0] = 17'd7; e.bids[5] = 17'h55; e.rid = 8'(exp_rid);
    sb.push_back(e);
    start = 1'b1; step(); start = 1'b0;        // cycle 1
    bid_valid = 10'h001; bid_data[0] = 17'd7;
    step();                                    // cycle 2
    n_checks++; if (bid_ready[0] !== 1'b0) $display("FAIL dup_ready0: got %b want 0", bid_ready[0]); else n_pass++;
    bid_data[0] = 17'd9;
    step(); bid_valid = '0;                    // cycle 3
    for (int k = 0; k < 5; k++) step();        // cycle 8, timer 7
    n_checks++; if (out_valid !== 1'b0) $display("FAIL close_early: out_valid=%b at cycle 8 want 0", out_valid); else n_pass++;
    bid_valid = 10'h020; bid_data[5] = 17'h55;
    step(); bid_valid = '0;                    // cycle 9
    n_checks++; if (out_valid !== 1'b1) $display("FAIL close_present: out_valid=%b at cycle 9 want 1", out_valid); else n_pass++;
    handshake();
  endtask

  task automatic test_backpressure();
    exp_t e;
    e = '0; e.mask = 10'h3FF; e.rid = 8'(exp_rid);
    for (int i = 0; i < 10; i++) e.bids[i] = bid_t'(20 + i);
    sb.push_back(e);
    start = 1'b1; step(); start = 1'b0;
    bid_valid = 10'h3FF;
    for (int i = 0; i < 10; i++) bid_data[i] = 17'(20 + i);
    step();
    for (int k = 0; k < 20; k++) begin
      start = k[0];
      for (int i = 0; i < 10; i++) bid_data[i] = 17'(100 + i + k);
      step();
    end
    bid_valid = '0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold: out_valid=%b want 1", out_valid); else n_pass++;
    start = 1'b1;
    handshake();
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release: out_valid=%b want 0", out_valid); else n_pass++;
    n_checks++; if (bid_ready !== '0) $display("FAIL bp_start_ignored: bid_ready=%h want 000", bid_ready); else n_pass++;
    step();
    n_checks++; if (bid_ready !== '0) $display("FAIL bp_still_idle: bid_ready=%h want 000", bid_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_collect();
    int bad;
    int seen;
    start = 1'b1; step(); start = 1'b0;
    bid_valid = 10'h003; bid_data[0] = 17'h111; bid_data[1] = 17'h222;
    step(); bid_valid = '0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    exp_rid = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) if (bids[i] !== '0) bad++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (bid_ready !== '0) $display("FAIL rst_bid_ready: got %h want 000", bid_ready); else n_pass++;
    n_checks++; if (bid_mask !== '0) $display("FAIL rst_bid_mask: got %h want 000", bid_mask); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL rst_bids: %0d nonzero slots, want 0", bad); else n_pass++;
    n_checks++; if (round_id !== 8'd0) $display("FAIL rst_round_id: got %0d want 0", round_id); else n_pass++;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen++;
      step();
    end
    n_checks++; if (seen !== 0) $display("FAIL rst_discard: presented %0d cycles, want 0", seen); else n_pass++;
  endtask

  task automatic test_empty_round();
    int bad8, bad4, seen;
    bad8 = 0; bad4 = 0; seen = 0;
    start = 1'b1; step(); start = 1'b0;        // cycle 1
    for (int c = 1; c <= 12; c++) begin
      if (o4_bid_ready !== ((c <= 4) ? 10'h3FF : 10'h000)) bad4++;
      if (bid_ready !== ((c <= 8) ? 10'h3FF : 10'h000)) bad8++;
      if (out_valid || o4_out_valid) seen++;
      step();
    end
    n_checks++; if (bad4 !== 0) $display("FAIL empty_window_tmo4: %0d cycles with wrong bid_ready, want 0", bad4); else n_pass++;
    n_checks++; if (bad8 !== 0) $display("FAIL empty_window_tmo8: %0d cycles with wrong bid_ready, want 0", bad8); else n_pass++;
    n_checks++; if (seen !== 0) $display("FAIL empty_present: out_valid seen %0d cycles, want 0", seen); else n_pass++;
    n_checks++; if (o4_round_id !== 8'd0) $display("FAIL empty_round_id4: got %0d want 0", o4_round_id); else n_pass++;
    n_checks++; if (round_id !== 8'(exp_rid)) $display("FAIL empty_round_id: got %0d want %0d", round_id, exp_rid); else n_pass++;
  endtask

  task automatic test_wrap();
    exp_t e;
    int   late;
    late = 0;
    for (int r = 0; r < 256; r++) begin
      e = '0; e.mask = 10'h3FF; e.rid = 8'(exp_rid);
      for (int i = 0; i < 10; i++) e.bids[i] = bid_t'(r * 10 + i);
      sb.push_back(e);
      start = 1'b1; step(); start = 1'b0;
      bid_valid = 10'h3FF;
      for (int i = 0; i < 10; i++) bid_data[i] = 17'(r * 10 + i);
      step(); bid_valid = '0;
      if (!out_valid) late++;
      handshake();
    end
    n_checks++; if (late !== 0) $display("FAIL wrap_latency: %0d rounds not presented on time, want 0", late); else n_pass++;
    n_checks++; if (round_id !== 8'd0) $display("FAIL wrap_round_id: got %0d want 0", round_id); else n_pass++;
    n_checks++; if (o4_round_id !== 8'd0) $display("FAIL wrap_round_id4: got %0d want 0", o4_round_id); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_round();
    test_timeout();
    test_duplicate_and_closing();
    test_backpressure();
    test_reset_mid_collect();
    test_empty_round();
    test_wrap();
    step();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL sb_drain: %0d expected rounds never presented, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bid_collect10.md
BID_COLLECT10 -- requirements
Module: bid_collect10

Interface
REQ-001 Parameter bW, default 17: bid width in bits.
REQ-002 Parameter NB, default 10: number of bidder slots; fixed at 10 for this block.
REQ-003 Parameter TMO, default 64: collection window length in cycles, legal range 2..255.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset; synchronous, active-high.
REQ-006 start  in  1: open a new round; single-cycle pulse.
REQ-007 bid_valid  in  [9:0]: per-slot bid offer.
REQ-008 bid_data  in  [bW-1:0] x 10 (unpacked [9:0]): per-slot bid value.
REQ-009 bid_ready  out  [9:0]: per-slot accept.
REQ-010 bids  out  [bW-1:0] x 10 (unpacked [9:0]): collected bid vector; this is the argmax stage input.
REQ-011 bid_mask  out  [9:0]: slot submitted a bid this round.
REQ-012 out_valid  out  1: bid vector presented.
REQ-013 out_ready  in  1: downstream accepts the vector.
REQ-014 round_id  out  [7:0]: count of presented rounds, wraps modulo 256.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT and PRESENT.
REQ-016 IDLE: bid_ready=0 and out_valid=0; start=1 moves the FSM to COLLECT and clears bids, bid_mask and the window timer.
REQ-017 COLLECT: bid_ready[i] = ~bid_mask[i]; when bid_valid[i]&bid_ready[i], bid_data[i] is captured into bids[i] and bid_mask[i] is set next cycle.
REQ-018 A slot SHALL be accepted at most once per round; further offers see bid_ready[i]=0.
REQ-019 The timer SHALL increment each COLLECT cycle; the window closes on the cycle where the timer equals TMO-1, or on the cycle the final unmasked slot is accepted.
REQ-020 Bids handshaken on the closing cycle SHALL be captured.
REQ-021 On close with a nonzero resulting mask, the FSM moves to PRESENT, so out_valid asserts 1 cycle after the closing cycle.
REQ-022 On close with mask==0 (empty round), the FSM returns to IDLE, out_valid never asserts and round_id is unchanged.
REQ-023 PRESENT: out_valid=1 and bid_ready=0; bids and bid_mask are held stable until out_ready.
REQ-024 PRESENT with out_ready=1: the FSM moves to IDLE and round_id increments by 1 (255 wraps to 0).
REQ-025 Unsubmitted slots SHALL present bids[i]=0.
REQ-026 start SHALL be ignored in COLLECT and PRESENT; start on the same cycle as the PRESENT handshake is ignored.
REQ-027 bid_valid SHALL be ignored outside COLLECT.
REQ-028 No combinational path from bid_valid or out_ready to bid_ready or out_valid; both outputs are decoded from state and mask registers only.

Reset
REQ-029 rst=1 SHALL force IDLE in the next cycle, from any state including mid-COLLECT and mid-PRESENT.
REQ-030 After rst: out_valid=0, bid_ready=0, bids all 0, bid_mask=0, round_id=0, timer=0.
REQ-031 A partially collected round SHALL be discarded by rst and never presented.

Structure
REQ-032 Shared package auction_pkg SHALL hold bW, NB, typedef bid_t (logic [bW-1:0]) and the FSM state enum; the argmax stage uses the same package.
REQ-033 One sub-module, bid_slot (capture register, mask bit, ready decode), SHALL be instantiated 10 times; the FSM and timer stay in bid_collect10.
REQ-034 Total RTL SHALL be 120-400 lines.

Verification
REQ-035 Full round: start; all 10 slots valid in cycle 1 with values 5..14 -> bid_mask=0x3FF, out_valid at cycle 2, bids[9]=14, round_id 0->1 after out_ready.
REQ-036 Timeout: TMO=8, only slot 3 bids (value 0x1FFFF) at cycle 2 -> out_valid 1 cycle after timer=7, bid_mask=0x008, all other bids=0.
REQ-037 Empty round: TMO=4, no bids -> FSM returns to IDLE, out_valid stays 0, round_id unchanged.
REQ-038 Duplicate and closing-cycle bids: slot 0 offers 7 then 9 -> bids[0]=7; a slot offering on the timer=TMO-1 cycle is captured.
REQ-039 Backpressure and reset: out_ready held 0 for 20 cycles -> bids stable and start ignored; rst in mid-COLLECT -> all outputs 0 the next cycle and no presentation.
REQ-040 Wrap: 256 presented rounds -> round_id returns to 0.
